// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: {bout, d} = a - b - bin, LSB first, one bit per clock.
// A single full-subtractor cell is fed from shift registers, with a start/done handshake.
module serial_subtractor #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         ov,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic           br;
  logic [N-1:0]   areg;
  logic [N-1:0]   breg;
  logic [N-1:0]   wreg;
  logic           last;
  logic           load;
  logic           dbit;
  logic           br_nx;

  assign last = (cnt == CW'(N - 1));
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // Operand registers shift right, so bit 0 is always the current bit i.
  always_comb begin
    dbit  = areg[0] ^ breg[0] ^ br;
    br_nx = (~areg[0] & breg[0]) | (~(areg[0] ^ breg[0]) & br);
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = SHIFT;
          load     = 1'b1;
        end
      end
      SHIFT: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (start) begin
          state_nx = SHIFT;
          load     = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      br   <= 1'b0;
      areg <= '0;
      breg <= '0;
      wreg <= '0;
      d    <= '0;
      bout <= 1'b0;
      ov   <= 1'b0;
    end else if (load) begin
      cnt  <= '0;
      br   <= bin;
      areg <= a;
      breg <= b;
      wreg <= '0;
    end else if (state == SHIFT) begin
      cnt  <= cnt + CW'(1);
      br   <= br_nx;
      areg <= areg >> 1;
      breg <= breg >> 1;
      wreg <= {dbit, wreg[N-1:1]};
      // On the final bit br is the borrow into the MSB, br_nx the borrow out of it.
      if (last) begin
        d    <= {dbit, wreg[N-1:1]};
        bout <= br_nx;
        ov   <= br ^ br_nx;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, handshake corner cases,
// exhaustive sweep and random operations against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic [N-1:0] d;
  logic         bout;
  logic         ov;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .d    (d),
    .bout (bout),
    .ov   (ov),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic [N-1:0] ed;
    logic         ebout;
    logic         eov;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed readings.
  function automatic void model(input int ua, input int ub, input int ubin,
                                output logic [N-1:0] md, output logic mbout, output logic mov);
    int u, sa, sb, s;
    u     = ua - ub - ubin;
    mbout = (u < 0);
    md    = N'((u + (1 << (N + 1))) % (1 << N));
    sa    = (ua >= (1 << (N - 1))) ? ua - (1 << N) : ua;
    sb    = (ub >= (1 << (N - 1))) ? ub - (1 << N) : ub;
    s     = sa - sb - ubin;
    mov   = (s < -(1 << (N - 1))) || (s > (1 << (N - 1)) - 1);
  endfunction

  // Called at a negedge; returns just after the accepting edge with garbage on the operands.
  task automatic start_op(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vbin);
    a     = va;
    b     = vb;
    bin   = vbin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = N'($urandom);
    b     = N'($urandom);
    bin   = 1'($urandom);
  endtask

  // Counts negedges until done is seen, and busy samples before it; bounded.
  task automatic wait_done(output int nneg, output int nbusy);
    nneg  = 0;
    nbusy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      nneg++;
      if (done) break;
      if (busy) nbusy++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic run_check(input string tag, input int va, input int vb, input int vbin);
    logic [N-1:0] md;
    logic         mb, mo;
    int           nn, nb;
    model(va, vb, vbin, md, mb, mo);
    start_op(N'(va), N'(vb), 1'(vbin));
    wait_done(nn, nb);
    if (d !== md || bout !== mb || ov !== mo || nn != N + 1) begin
      check($sformatf("%s a=%0d b=%0d bin=%0d d", tag, va, vb, vbin), 32'(d), 32'(md));
      check($sformatf("%s a=%0d b=%0d bin=%0d bout", tag, va, vb, vbin), 32'(bout), 32'(mb));
      check($sformatf("%s a=%0d b=%0d bin=%0d ov", tag, va, vb, vbin), 32'(ov), 32'(mo));
      check($sformatf("%s a=%0d b=%0d bin=%0d latency", tag, va, vb, vbin), 32'(nn), 32'(N + 1));
    end else begin
      total++;
    end
  endtask

  initial begin
    int nn, nb;
    logic [N-1:0] md;
    logic         mb, mo;

    vecs[0] = '{a: 7,  b: 3,  bin: 0, ed: 4,  ebout: 0, eov: 0};
    vecs[1] = '{a: 3,  b: 7,  bin: 0, ed: 28, ebout: 1, eov: 0};
    vecs[2] = '{a: 0,  b: 0,  bin: 1, ed: 31, ebout: 1, eov: 0};
    vecs[3] = '{a: 16, b: 1,  bin: 0, ed: 15, ebout: 0, eov: 1};
    vecs[4] = '{a: 15, b: 31, bin: 0, ed: 16, ebout: 1, eov: 1};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset d", 32'(d), 0);
    check("reset bout", 32'(bout), 0);
    check("reset ov", 32'(ov), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
      wait_done(nn, nb);
      check($sformatf("vec%0d busy_cycles", i), 32'(nb), 32'(N));
      check($sformatf("vec%0d done_at", i), 32'(nn), 32'(N + 1));
      check($sformatf("vec%0d d", i), 32'(d), 32'(vecs[i].ed));
      check($sformatf("vec%0d bout", i), 32'(bout), 32'(vecs[i].ebout));
      check($sformatf("vec%0d ov", i), 32'(ov), 32'(vecs[i].eov));
      @(negedge clk);
      check($sformatf("vec%0d done_pulse_end", i), 32'(done), 0);
      check($sformatf("vec%0d d_held", i), 32'(d), 32'(vecs[i].ed));
      check($sformatf("vec%0d ov_held", i), 32'(ov), 32'(vecs[i].eov));
    end

    // Start mid-operation must be ignored.
    start_op(7, 3, 0);
    @(negedge clk);
    @(negedge clk);
    a     = 1;
    b     = 2;
    bin   = 1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(nn, nb);
    check("ignore done_at", 32'(nn), 4);
    check("ignore d", 32'(d), 4);
    check("ignore bout", 32'(bout), 0);

    // Back-to-back start during the DONE cycle.
    start_op(10, 3, 1);
    wait_done(nn, nb);
    check("b2b busy_cycles", 32'(nb), 32'(N));
    check("b2b done_at", 32'(nn), 32'(N + 1));
    check("b2b d", 32'(d), 6);

    // Start held high: each operation re-samples operands at its accepting edge.
    @(negedge clk);
    a = 9; b = 4; bin = 0; start = 1'b1;
    @(posedge clk);
    #1;
    a = 2; b = 5; bin = 0;
    wait_done(nn, nb);
    check("held1 d", 32'(d), 5);
    @(posedge clk);
    #1;
    a = 20; b = 20;
    wait_done(nn, nb);
    start = 1'b0;
    check("held2 done_at", 32'(nn), 32'(N + 1));
    check("held2 d", 32'(d), 29);
    check("held2 bout", 32'(bout), 1);
    @(negedge clk);

    // Reset mid-SHIFT aborts with no done pulse.
    start_op(20, 5, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort d", 32'(d), 0);
    check("abort bout", 32'(bout), 0);
    check("abort ov", 32'(ov), 0);
    check("abort busy", 32'(busy), 0);
    check("abort done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    nn = 0;
    for (int k = 0; k < 2 * N; k++) begin
      @(negedge clk);
      if (done || busy) nn++;
    end
    check("abort no_done", 32'(nn), 0);

    for (int ia = 0; ia < (1 << N); ia++)
      for (int ib = 0; ib < (1 << N); ib++)
        for (int ic = 0; ic < 2; ic++)
          run_check("sweep", ia, ib, ic);

    for (int r = 0; r < 200; r++)
      run_check("rand", int'($urandom_range((1 << N) - 1)), int'($urandom_range((1 << N) - 1)),
                int'($urandom_range(1)));

    model(0, 1, 0, md, mb, mo);
    start_op(0, 1, 0);
    wait_done(nn, nb);
    check("final d", 32'(d), 32'(md));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
